// File: rtl/mac_stream_accum.sv
// Streaming multi-lane multiply-accumulate engine.
// Each lane folds a*b into a bias-loaded accumulator.

module mac_unit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic        mode,
  output logic [15:0] out
);

  function automatic logic [10:0] sig(
    input logic [15:0] h
  );
    return {|h[14:10], h[9:0]};
  endfunction

  function automatic logic [6:0] ex(
    input logic [15:0] h
  );
    return (h[14:10] == 5'd0) ? 7'd1
                              : {2'b0, h[14:10]};
  endfunction

  logic [15:0] iv;
  logic [21:0] pm;
  logic [6:0]  psh;
  logic [83:0] pmag;
  logic [83:0] cmag;
  logic [83:0] sval;
  logic [83:0] mag;
  logic [83:0] mask;
  logic [6:0]  p;
  logic [6:0]  sh;
  logic [11:0] mant;
  logic [11:0] m;
  logic [5:0]  eb;
  logic [15:0] r;
  logic [15:0] fp;
  logic        ps;
  logic        rs;
  logic        grd;
  logic        stk;
  logic        a_inf, b_inf, c_inf;
  logic        a_nan, b_nan, c_nan;
  logic        p_inf, p_nan;

  // INT16 wraps; FP16 is a fused multiply-add:
  // exact fixed-point sum (lsb 2^-48) then one RNE rounding
  always_comb begin
    iv    = a * b + c;
    pm    = 22'(sig(a)) * 22'(sig(b));
    psh   = ex(a) + ex(b) - 7'd2;
    pmag  = 84'(pm) << psh;
    cmag  = 84'(sig(c)) << (ex(c) + 7'd23);
    ps    = a[15] ^ b[15];
    sval  = (ps ? -pmag : pmag)
          + (c[15] ? -cmag : cmag);
    rs    = sval[83];
    mag   = rs ? -sval : sval;
    p     = 7'd0;
    for (int i = 0; i < 84; i++) begin
      if (mag[i]) p = 7'(i);
    end
    sh    = (p >= 7'd34) ? p - 7'd10 : 7'd24;
    mant  = 12'(mag >> sh);
    grd   = mag[sh - 7'd1];
    mask  = (84'd1 << (sh - 7'd1)) - 84'd1;
    stk   = |(mag & mask);
    m     = mant + {11'd0, grd & (stk | mant[0])};
    eb    = (p >= 7'd34) ? 6'(p - 7'd34) : 6'd0;
    r     = {eb, 10'd0} + {4'd0, m};
    a_inf = (&a[14:10]) && (a[9:0] == 10'd0);
    b_inf = (&b[14:10]) && (b[9:0] == 10'd0);
    c_inf = (&c[14:10]) && (c[9:0] == 10'd0);
    a_nan = (&a[14:10]) && (a[9:0] != 10'd0);
    b_nan = (&b[14:10]) && (b[9:0] != 10'd0);
    c_nan = (&c[14:10]) && (c[9:0] != 10'd0);
    p_inf = a_inf | b_inf;
    p_nan = a_nan | b_nan
          | (a_inf & (b[14:0] == 15'd0))
          | (b_inf & (a[14:0] == 15'd0));
    if (mag == 84'd0) begin
      fp = {ps & c[15] & (pm == 22'd0)
               & (sig(c) == 11'd0), 15'd0};
    end else if (r >= 16'h7C00) begin
      fp = {rs, 15'h7C00};
    end else begin
      fp = {rs, r[14:0]};
    end
    if (p_nan | c_nan
        | (p_inf & c_inf & (ps != c[15])))
      fp = 16'h7E00;
    else if (p_inf)
      fp = {ps, 15'h7C00};
    else if (c_inf)
      fp = c;
    out = mode ? fp : iv;
  end

endmodule

module mac_stream_accum #(
  parameter int LANES = 4,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     start_len,
  input  logic                 start_mode,
  input  logic [16*LANES-1:0]  start_bias,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_a,
  input  logic [16*LANES-1:0]  in_b,
  input  logic                 flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [16*LANES-1:0]  res_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [LEN_W-1:0]    rem;
  logic                mode_q;
  logic [16*LANES-1:0] acc;
  logic [16*LANES-1:0] mac_out;
  logic                load;
  logic                beat;

  assign load = (state == IDLE) && start && !flush;
  assign beat = (state == RUN) && in_valid && !flush;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_unit u_mac (
      .a    (in_a[16*i +: 16]),
      .b    (in_b[16*i +: 16]),
      .c    (acc[16*i +: 16]),
      .mode (mode_q),
      .out  (mac_out[16*i +: 16])
    );
  end

  // Next-state: flush wins everywhere, start only from IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load)
          state_nx = (start_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (flush)
          state_nx = IDLE;
        else if (in_valid && rem == LEN_W'(1))
          state_nx = DONE;
      end
      DONE: begin
        if (flush || res_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Job registers: bias load on start, fold on each beat
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      rem    <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      acc    <= start_bias;
      rem    <= start_len;
      mode_q <= start_mode;
    end else if (beat) begin
      acc    <= mac_out;
      rem    <= rem - LEN_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

endmodule

// File: tb/tb_mac_stream_accum.sv
// Bench for mac_stream_accum: directed literal cases
// plus random jobs against a real-arithmetic model.

module tb_mac_stream_accum;

  localparam int LANES = 4;
  localparam int LEN_W = 8;
  localparam int DW    = 16 * LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] start_len;
  logic             start_mode;
  logic [DW-1:0]    start_bias;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mac_stream_accum #(
    .LANES (LANES),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_len  (start_len),
    .start_mode (start_mode),
    .start_bias (start_bias),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    for (int i = 0; i > n; i--) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  f = int'(h[9:0]);
    real v;
    if (e == 0) v = f * pow2(-24);
    else        v = (f + 1024) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Round a real to the nearest half, ties to even
  function automatic logic [15:0] r2h(
    input real x,
    input logic zs
  );
    real    ax, q, n, fl;
    int     e;
    longint li;
    logic   s;
    logic [15:0] bits;
    if (x == 0.0) return {zs, 15'd0};
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = -14;
    if (ax < pow2(-14)) q = pow2(-24);
    else begin
      while (ax >= pow2(e + 1) && e < 40) e++;
      q = pow2(e - 10);
    end
    n  = ax / q;
    fl = $floor(n);
    li = longint'(fl);
    if ((n - fl) > 0.5 || ((n - fl) == 0.5 && li[0]))
      li++;
    if (ax < pow2(-14)) bits = 16'(li);
    else bits = 16'(((e + 14) * 1024) + li);
    if (bits >= 16'h7C00) bits = 16'h7C00;
    return {s, bits[14:0]};
  endfunction

  function automatic logic [15:0] mac_ref(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic        md
  );
    real pr;
    if (!md) return 16'((a * b + c) & 32'hFFFF);
    pr = h2r(a) * h2r(b);
    return r2h(pr + h2r(c),
               a[15] ^ b[15] & c[15] & (pr == 0.0)
               & (c[14:0] == 15'd0));
  endfunction

  // Reference: 0 idle, 1 taking beats, 2 holding result
  int          m_phase = 0;
  int          m_left  = 0;
  logic        m_mode  = 1'b0;
  logic [15:0] m_acc [LANES];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_mode  = 1'b0;
      for (int i = 0; i < LANES; i++) m_acc[i] = '0;
    end else if (m_phase == 0) begin
      if (start && !flush) begin
        m_mode = start_mode;
        m_left = int'(start_len);
        for (int i = 0; i < LANES; i++)
          m_acc[i] = start_bias[16*i +: 16];
        m_phase = (m_left == 0) ? 2 : 1;
      end
    end else if (flush) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (in_valid) begin
        for (int i = 0; i < LANES; i++)
          m_acc[i] = mac_ref(in_a[16*i +: 16],
                             in_b[16*i +: 16],
                             m_acc[i], m_mode);
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (res_ready) begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    if (chk_en) begin
      for (int i = 0; i < LANES; i++)
        ed[16*i +: 16] = m_acc[i];
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("in_ready", 64'(in_ready),
            64'(m_phase == 1));
      check("res_valid", 64'(res_valid),
            64'(m_phase == 2));
      check("res_data", res_data, ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(
    input int            len,
    input logic          md,
    input logic [DW-1:0] bias
  );
    start      = 1'b1;
    start_len  = LEN_W'(len);
    start_mode = md;
    start_bias = bias;
    tick();
    start = 1'b0;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [15:0] rnd_fp();
    logic [4:0] e = 5'($urandom_range(11, 19));
    return {1'($urandom_range(0, 1)), e,
            10'($urandom)};
  endfunction

  function automatic logic [15:0] rnd_op(input logic md);
    return md ? rnd_fp() : 16'($urandom);
  endfunction

  initial begin
    int cyc;
    logic md;
    rst = 1'b1; start = 0; start_len = '0;
    start_mode = 0; start_bias = '0;
    in_valid = 0; in_a = '0; in_b = '0;
    flush = 0; res_ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_data", res_data, 64'd0);
    check("model_fp", 64'(mac_ref(16'h3C00,
          16'h4000, 16'h3C00, 1'b1)), 64'h4200);

    in_a = {LANES{16'h0002}};
    in_b = {LANES{16'h0003}};
    in_valid = 1'b1;
    go(3, 1'b0, '0);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick(); cyc++;
    end
    in_valid = 1'b0;
    check("int_latency", 64'(cyc), 64'd3);
    check("int_data", res_data,
          {LANES{16'h0012}});
    release_res();
    check("int_idle", 64'(busy), 64'd0);

    in_a = {LANES{16'h3C00}};
    in_b = {LANES{16'h4000}};
    go(2, 1'b1, {LANES{16'h3C00}});
    in_valid = 1; tick();
    in_valid = 0; tick(); tick();
    in_valid = 1; tick();
    in_valid = 0;
    check("fp_valid", 64'(res_valid), 64'd1);
    check("fp_data", res_data, {LANES{16'h4500}});
    start = 1'b1; start_len = 8'd7;
    start_bias = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_data", res_data,
            {LANES{16'h4500}});
    end
    res_ready = 1'b1;
    tick();
    start = 1'b0; res_ready = 1'b0;
    check("bp_start_ign", 64'(busy), 64'd0);
    check("bp_keep", res_data, {LANES{16'h4500}});

    in_valid = 1'b1;
    go(0, 1'b0, 64'h0004_0003_0002_0001);
    in_valid = 1'b0;
    check("len0_valid", 64'(res_valid), 64'd1);
    check("len0_data", res_data,
          64'h0004_0003_0002_0001);
    release_res();

    in_a = {LANES{16'h0100}};
    in_b = {LANES{16'h0100}};
    go(1, 1'b0, {LANES{16'h0005}});
    in_valid = 1; tick(); in_valid = 0;
    check("wrap", res_data, {LANES{16'h0005}});
    release_res();
    in_a = 64'h0004_0003_0002_0001;
    in_b = 64'h0005_0006_0007_0008;
    go(1, 1'b0, '0);
    in_valid = 1; tick(); in_valid = 0;
    check("lanes", res_data,
          64'h0014_0012_000E_0008);
    release_res();

    in_a = {LANES{16'h0002}};
    in_b = {LANES{16'h0002}};
    go(4, 1'b0, {LANES{16'h0033}});
    in_valid = 1; tick(); in_valid = 0;
    rst = 1; tick(); rst = 0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_data", res_data, 64'd0);

    in_a = {LANES{16'h0001}};
    in_b = {LANES{16'h0001}};
    go(3, 1'b0, {LANES{16'h0010}});
    in_valid = 1; tick();
    flush = 1; tick();
    flush = 0; in_valid = 0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_data", res_data,
          {LANES{16'h0011}});
    in_a = {LANES{16'h0002}};
    in_b = {LANES{16'h0002}};
    go(1, 1'b0, {LANES{16'h0100}});
    in_valid = 1; tick(); in_valid = 0;
    check("after_flush", res_data,
          {LANES{16'h0104}});
    release_res();

    for (int j = 0; j < 40; j++) begin
      md = 1'($urandom_range(0, 1));
      for (int i = 0; i < LANES; i++)
        start_bias[16*i +: 16] = rnd_op(md);
      go($urandom_range(0, 8), md, start_bias);
      cyc = 0;
      while (busy && cyc < 200) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        res_ready = 1'($urandom_range(0, 1));
        flush     = ($urandom_range(0, 29) == 0);
        start     = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < LANES; i++) begin
          in_a[16*i +: 16] = rnd_op(md);
          in_b[16*i +: 16] = rnd_op(md);
        end
        tick(); cyc++;
        start = 0; flush = 0;
      end
      in_valid = 0; res_ready = 0;
      check("job_bound", 64'(cyc < 200), 64'd1);
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
